// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the single-read-port RAM controller: FSM state
// encodings and the request-to-response latency of a read.
package ram_ctrl_pkg;

    localparam logic [1:0] ST_CLEAR      = 2'd0;
    localparam logic [1:0] ST_IDLE       = 2'd1;
    localparam logic [1:0] ST_RD_ISSUE   = 2'd2;
    localparam logic [1:0] ST_RD_CAPTURE = 2'd3;

    localparam int RD_LATENCY = 3;

endpackage

// File: rtl/ram_port_controller.sv
// Client-side controller for a single-read-port synchronous RAM: registered
// writes, fixed-latency reads with a one-cycle response pulse, and a zero-fill sweep.
module ram_port_controller
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_SIZE   = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iReqValid,
    output logic                  oReqReady,
    input  logic                  iReqWrite,
    input  logic [ADDR_WIDTH-1:0] iReqAddress,
    input  logic [DATA_WIDTH-1:0] iReqData,
    input  logic                  iClearStart,
    output logic                  oRspValid,
    output logic [DATA_WIDTH-1:0] oRspData,
    output logic                  oAddrError,
    output logic                  oBusy,
    output logic                  oRamWriteEnable,
    output logic [ADDR_WIDTH-1:0] oRamWriteAddress,
    output logic [ADDR_WIDTH-1:0] oRamReadAddress,
    output logic [DATA_WIDTH-1:0] oRamDataOut,
    input  logic [DATA_WIDTH-1:0] iRamDataIn,
    output logic [1:0]            oDbgState
);

    localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(MEM_SIZE);

    // Handshake: a request transfers in any cycle where iReqValid and
    // oReqReady are both high; oReqReady is high only in IDLE.

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_clear_cnt;
    logic                  r_rd_oob;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_addr_err;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic w_hs;
    logic w_oob;

    assign w_hs  = iReqValid && (r_state == ST_IDLE);
    assign w_oob = iReqAddress > LP_LAST_ADDR;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state     <= ST_CLEAR;
            r_clear_cnt <= '0;
            r_rd_oob    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_addr_err  <= 1'b0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_raddr     <= '0;
            r_wdata     <= '0;
        end else begin
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_addr_err  <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_we    <= 1'b1;
                    r_waddr <= r_clear_cnt;
                    r_wdata <= '0;
                    if (r_clear_cnt == LP_LAST_ADDR) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_clear_cnt <= r_clear_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    // A request in the same cycle as iClearStart takes priority.
                    if (w_hs) begin
                        r_addr_err <= w_oob;
                        if (iReqWrite) begin
                            if (!w_oob) begin
                                r_we    <= 1'b1;
                                r_waddr <= iReqAddress;
                                r_wdata <= iReqData;
                            end
                        end else begin
                            r_raddr  <= iReqAddress;
                            r_rd_oob <= w_oob;
                            r_state  <= ST_RD_ISSUE;
                        end
                    end else if (iClearStart) begin
                        r_clear_cnt <= '0;
                        r_state     <= ST_CLEAR;
                    end
                end
                ST_RD_ISSUE: begin
                    r_state <= ST_RD_CAPTURE;
                end
                ST_RD_CAPTURE: begin
                    // Out-of-range reads still answer, but with zero data.
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= r_rd_oob ? '0 : iRamDataIn;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oReqReady        = (r_state == ST_IDLE);
    assign oBusy            = (r_state == ST_CLEAR);
    assign oRspValid        = r_rsp_valid;
    assign oRspData         = r_rsp_data;
    assign oAddrError       = r_addr_err;
    assign oRamWriteEnable  = r_we;
    assign oRamWriteAddress = r_waddr;
    assign oRamReadAddress  = r_raddr;
    assign oRamDataOut      = r_wdata;
    assign oDbgState        = r_state;

endmodule

// File: tb/tb_ram_port_controller.sv
// Bench for ram_port_controller with a behavioural RAM attached; expected
// behaviour comes from a cycle-indexed reference model of the controller rules.
module tb_ram_port_controller;
    import ram_ctrl_pkg::*;

    localparam int DW   = 16;
    localparam int AW   = 8;
    localparam int MS   = 8;
    localparam int MAXC = 4096;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          iReqValid = 1'b0;
    logic          iReqWrite = 1'b0;
    logic [AW-1:0] iReqAddress = '0;
    logic [DW-1:0] iReqData = '0;
    logic          iClearStart = 1'b0;
    logic          oReqReady, oRspValid, oAddrError, oBusy, oRamWriteEnable;
    logic [DW-1:0] oRspData, oRamDataOut, iRamDataIn;
    logic [AW-1:0] oRamWriteAddress, oRamReadAddress;
    logic [1:0]    dbg_state;

    ram_port_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
        .Clock(Clock), .Reset(Reset),
        .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqWrite(iReqWrite),
        .iReqAddress(iReqAddress), .iReqData(iReqData), .iClearStart(iClearStart),
        .oRspValid(oRspValid), .oRspData(oRspData), .oAddrError(oAddrError),
        .oBusy(oBusy), .oRamWriteEnable(oRamWriteEnable),
        .oRamWriteAddress(oRamWriteAddress), .oRamReadAddress(oRamReadAddress),
        .oRamDataOut(oRamDataOut), .iRamDataIn(iRamDataIn), .oDbgState(dbg_state)
    );

    // clock / reset / RAM
    always #5 Clock = ~Clock;

    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] ram_q;
    always @(posedge Clock) begin
        if (oRamWriteEnable) ram[oRamWriteAddress] <= oRamDataOut;
        ram_q <= ram[oRamReadAddress];
    end
    assign iRamDataIn = ram_q;

    int cyc = 0;
    always @(posedge Clock) cyc = cyc + 1;

    // reference model and scoreboard
    bit            exp_we    [MAXC];
    logic [AW-1:0] exp_waddr [MAXC];
    logic [DW-1:0] exp_wdata [MAXC];
    bit            exp_err   [MAXC];
    bit            exp_rd    [MAXC];
    logic [AW-1:0] exp_raddr [MAXC];
    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [DW-1:0] ref_mem [0:MS];
    int ready_from = MAXC;
    int busy_lo = 0;
    int sweep_end = 0;
    bit chk_en = 1'b0;
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MAXC; i++) begin
            exp_we[i] = 1'b0;
            exp_err[i] = 1'b0;
            exp_rd[i] = 1'b0;
        end
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    // A sweep whose first CLEAR cycle is s writes address k in cycle s+1+k.
    task automatic start_clear(input int s);
        busy_lo    = s;
        sweep_end  = s + MS + 1;
        ready_from = sweep_end;
        for (int k = 0; k <= MS; k++) begin
            exp_we[s + 1 + k]    = 1'b1;
            exp_waddr[s + 1 + k] = AW'(k);
            exp_wdata[s + 1 + k] = '0;
            ref_mem[k] = '0;
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_ready", oReqReady, 0);
        chk("rst_rsp_valid", oRspValid, 0);
        chk("rst_rsp_data", oRspData, 0);
        chk("rst_addr_err", oAddrError, 0);
        chk("rst_busy", oBusy, 1);
        chk("rst_we", oRamWriteEnable, 0);
        chk("rst_waddr", oRamWriteAddress, 0);
        chk("rst_raddr", oRamReadAddress, 0);
        chk("rst_wdata", oRamDataOut, 0);
    endtask

    always @(negedge Clock) begin
        int  c;
        bit  rdy;
        bit  due;
        if (Reset && chk_en && cyc < MAXC - 16) begin
            c = cyc;
            rdy = (c >= ready_from);
            chk("ready", oReqReady, rdy);
            chk("busy", oBusy, (c >= busy_lo) && (c < sweep_end));
            chk("we", oRamWriteEnable, exp_we[c]);
            if (exp_we[c]) begin
                chk("waddr", oRamWriteAddress, exp_waddr[c]);
                chk("wdata", oRamDataOut, exp_wdata[c]);
            end
            if (exp_rd[c]) chk("raddr", oRamReadAddress, exp_raddr[c]);
            chk("addr_err", oAddrError, exp_err[c]);
            due = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == c);
            chk("rsp_valid", oRspValid, due);
            if (due) chk("rsp_data", oRspData, exp_q[0]);
            while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= c) begin
                void'(exp_cyc_q.pop_front());
                void'(exp_q.pop_front());
            end
            if (iReqValid && rdy) begin
                exp_err[c + 1] = (iReqAddress > MS);
                if (iReqWrite) begin
                    if (iReqAddress <= MS) begin
                        ref_mem[iReqAddress] = iReqData;
                        exp_we[c + 1]    = 1'b1;
                        exp_waddr[c + 1] = iReqAddress;
                        exp_wdata[c + 1] = iReqData;
                    end
                end else begin
                    exp_rd[c + 1]    = 1'b1;
                    exp_raddr[c + 1] = iReqAddress;
                    if (iReqAddress <= MS) exp_q.push_back(ref_mem[iReqAddress]);
                    else exp_q.push_back('0);
                    exp_cyc_q.push_back(c + RD_LATENCY);
                    ready_from = c + RD_LATENCY;
                end
            end else if (iClearStart && rdy) begin
                start_clear(c + 1);
            end
        end
    end

    // driver tasks
    task automatic wait_ready();
        int n = 0;
        while (cyc < ready_from && n < 200) begin
            @(posedge Clock); #1;
            n++;
        end
        if (n >= 200) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input bit w, input int a, input logic [DW-1:0] d, input bit clr);
        wait_ready();
        iReqValid   = 1'b1;
        iReqWrite   = w;
        iReqAddress = AW'(a);
        iReqData    = d;
        iClearStart = clr;
        @(posedge Clock); #1;
        iReqValid   = 1'b0;
        iClearStart = 1'b0;
    endtask

    task automatic clear_pulse();
        iClearStart = 1'b1;
        @(posedge Clock); #1;
        iClearStart = 1'b0;
    endtask

    task automatic release_reset();
        model_reset();
        start_clear(cyc);
        Reset  = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        #2;
        check_reset_vals();
        repeat (3) @(posedge Clock);
        #1;
        release_reset();
        wait_ready();

        // write then immediate read of the same address
        send(1, 3, 16'hBEEF, 0);
        send(0, 3, '0, 0);

        // out-of-range read and write
        send(0, 9, '0, 0);
        send(1, 9, 16'h5555, 0);
        send(0, 9, '0, 0);

        // back-to-back writes over the whole range, then read back
        for (int a = 0; a <= MS; a++) send(1, a, DW'(a * 16'h0101), 0);
        for (int a = 0; a <= MS; a++) send(0, a, '0, 0);

        // clear request loses to a write, then a lone clear runs the sweep
        send(1, 2, 16'h1234, 1);
        clear_pulse();
        send(0, 2, '0, 0);
        send(0, 3, '0, 0);

        // random traffic
        for (int i = 0; i < 250; i++) begin
            iReqValid   = ($urandom_range(0, 3) != 0);
            iReqWrite   = $urandom_range(0, 1);
            iReqAddress = AW'($urandom_range(0, 11));
            iReqData    = DW'($urandom);
            iClearStart = ($urandom_range(0, 24) == 0);
            @(posedge Clock); #1;
        end
        iReqValid   = 1'b0;
        iClearStart = 1'b0;

        // reset during RD_ISSUE
        send(1, 5, 16'hA5A5, 0);
        send(0, 5, '0, 0);
        #1;
        Reset  = 1'b0;
        chk_en = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) @(posedge Clock);
        #1;
        release_reset();
        send(0, 5, '0, 0);
        send(1, 7, 16'h0F0F, 0);
        send(0, 7, '0, 0);
        repeat (6) @(posedge Clock);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #(MAXC * 10);
        n_errors++;
        $display("FAIL watchdog: simulation did not finish within %0d cycles", MAXC);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
